mac_operand_feeder: RTL and testbench

Front-end sequencer for the low-power pipelined MAC. It accepts a dot-product command of N operand pairs and streams the pairs from a valid/ready source into the MAC's `enable`/`b_in`/`c_in` port. It then flushes the MAC pipeline with zero operands, captures the accumulator output and returns it on a valid/ready result channel. Operands are forced to zero whenever `mac_enable` is low, which provides operand isolation at the MAC boundary.

---
 rtl/mac_operand_feeder_if.sv | 42 ++++
 rtl/mac_operand_feeder.sv | 129 ++++++++++++
 tb/tb_mac_operand_feeder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_feeder_if.sv
// mac_operand_feeder_if
//   Bundles the four channels around the MAC operand feeder:
//   - cmd_*    : job request (pair count) into the feeder.
//   - op_*     : valid/ready stream of operand pairs into the feeder.
//   - mac_*    : registered operand port toward the MAC (enable/b_in/c_in),
//                plus mac_in carrying the MAC accumulator back.
//   - res_*    : valid/ready result channel out of the feeder.
//   - busy     : feeder is not idle.
//   Modport slave is the feeder itself; modport master is its environment.
interface mac_operand_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_W-1:0]        cmd_len;
  logic                    op_valid;
  logic                    op_ready;
  logic [DATA_WIDTH-1:0]   op_b;
  logic [DATA_WIDTH-1:0]   op_c;
  logic                    mac_enable;
  logic [DATA_WIDTH-1:0]   mac_b;
  logic [DATA_WIDTH-1:0]   mac_c;
  logic [2*DATA_WIDTH:0]   mac_in;
  logic                    res_valid;
  logic                    res_ready;
  logic [2*DATA_WIDTH:0]   res_data;
  logic [LEN_W-1:0]        res_count;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_b, op_c, mac_in, res_ready,
    output cmd_ready, op_ready, mac_enable, mac_b, mac_c,
           res_valid, res_data, res_count, busy
  );

  modport master (
    output cmd_valid, cmd_len, op_valid, op_b, op_c, mac_in, res_ready,
    input  cmd_ready, op_ready, mac_enable, mac_b, mac_c,
           res_valid, res_data, res_count, busy
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
//   Front-end sequencer for the pipelined MAC. Accepts a job of cmd_len
//   operand pairs, streams them to the MAC with one cycle of latency,
//   issues DRAIN_CYCLES zero-operand enabled cycles to flush the MAC
//   pipeline, waits one idle cycle, captures the MAC accumulator and
//   presents it on the result channel until consumed.
//   Operands toward the MAC are zero whenever mac_enable is low.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : mac_operand_feeder_if.slave (cmd/op/mac/res channels, busy)
module mac_operand_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_operand_feeder_if.slave   bus
);

  localparam int RES_W = 2*DATA_WIDTH + 1;
  // One extra count beyond DRAIN_CYCLES is used for the idle cycle that
  // precedes CAPTURE, so the counter must hold DRAIN_CYCLES itself.
  localparam int DCW   = $clog2(DRAIN_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, CAPTURE, RESULT} state_t;

  state_t                 state;
  logic [LEN_W-1:0]       remaining;
  logic [DCW-1:0]         drain_cnt;

  logic                   vld_p1;
  logic [DATA_WIDTH-1:0]  mac_b_p1;
  logic [DATA_WIDTH-1:0]  mac_c_p1;

  logic                   res_valid_r;
  logic [RES_W-1:0]       res_data_r;
  logic [LEN_W-1:0]       res_count_r;

  logic                   cmd_ready;
  logic                   op_ready;
  logic                   cmd_fire;
  logic                   op_fire;
  logic                   res_fire;

  // Ready signals are gated by rst_n so no handshake completes during reset.
  assign cmd_ready = rst_n && (state == IDLE);
  assign op_ready  = rst_n && (state == STREAM) && (remaining != '0);
  assign cmd_fire  = bus.cmd_valid && cmd_ready;
  assign op_fire   = bus.op_valid && op_ready;
  assign res_fire  = res_valid_r && bus.res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      drain_cnt   <= '0;
      vld_p1      <= 1'b0;
      mac_b_p1    <= '0;
      mac_c_p1    <= '0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_count_r <= '0;
    end else begin
      // Operand isolation: anything not explicitly driven below is a
      // disabled, all-zero MAC cycle.
      vld_p1   <= 1'b0;
      mac_b_p1 <= '0;
      mac_c_p1 <= '0;
      case (state)
        IDLE: begin
          drain_cnt <= '0;
          if (cmd_fire) begin
            res_count_r <= bus.cmd_len;
            remaining   <= bus.cmd_len;
            state       <= (bus.cmd_len != '0) ? STREAM : CAPTURE;
          end
        end
        // p0 -> p1: accepted pair becomes the next MAC operand cycle
        STREAM: begin
          if (op_fire) begin
            vld_p1    <= 1'b1;
            mac_b_p1  <= bus.op_b;
            mac_c_p1  <= bus.op_c;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        // The registered enable lags the state by one cycle, so the final
        // count here schedules the idle cycle that CAPTURE samples at.
        DRAIN: begin
          if (drain_cnt == DCW'(DRAIN_CYCLES)) begin
            state <= CAPTURE;
          end else begin
            vld_p1    <= 1'b1;
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        CAPTURE: begin
          res_data_r  <= bus.mac_in;
          res_valid_r <= 1'b1;
          state       <= RESULT;
        end
        RESULT: begin
          if (res_fire) begin
            res_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.op_ready   = op_ready;
  assign bus.mac_enable = vld_p1;
  assign bus.mac_b      = mac_b_p1;
  assign bus.mac_c      = mac_c_p1;
  assign bus.res_valid  = res_valid_r;
  assign bus.res_data   = res_data_r;
  assign bus.res_count  = res_count_r;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder
//   Directed bench for mac_operand_feeder. mac_in is driven with a value
//   unique to each cycle, so res_data identifies the exact cycle sampled.
module tb_mac_operand_feeder;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int RW = 2*DW + 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_asrt;
  int   n_fail;

  mac_operand_feeder_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

  mac_operand_feeder #(
    .DATA_WIDTH   (DW),
    .LEN_W        (LW),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] marker(input int c);
    return RW'(c * 13 + 1);
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    bus.mac_in = marker(cyc);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asrt = n_asrt + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [RW-1:0] exp_res;
  int            dcnt;
  int            zcnt;
  int            ocnt;
  int            got;
  int            bad_ready;

  initial begin
    n_asrt = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_b      = '0;
    bus.op_c      = '0;
    bus.res_ready = 1'b0;
    bus.mac_in    = marker(0);

    // ---------------- reset state
    tick();
    tick();
    check("rst_mac_enable", 32'(bus.mac_enable), 0);
    check("rst_mac_b",      32'(bus.mac_b), 0);
    check("rst_mac_c",      32'(bus.mac_c), 0);
    check("rst_res_valid",  32'(bus.res_valid), 0);
    check("rst_res_data",   32'(bus.res_data), 0);
    check("rst_res_count",  32'(bus.res_count), 0);
    check("rst_busy",       32'(bus.busy), 0);
    check("rst_cmd_ready",  32'(bus.cmd_ready), 0);
    check("rst_op_ready",   32'(bus.op_ready), 0);
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", 32'(bus.cmd_ready), 1);

    // ---------------- back-to-back stream, len 3
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd3;
    bus.op_valid  = 1'b1;
    bus.op_b = 8'd2; bus.op_c = 8'd3;
    tick();
    bus.cmd_valid = 1'b0;
    check("b2b_busy",     32'(bus.busy), 1);
    check("b2b_cmd_rdy0", 32'(bus.cmd_ready), 0);
    check("b2b_op_rdy",   32'(bus.op_ready), 1);
    check("b2b_en_pre",   32'(bus.mac_enable), 0);
    tick();
    check("b2b_en0", 32'(bus.mac_enable), 1);
    check("b2b_b0",  32'(bus.mac_b), 2);
    check("b2b_c0",  32'(bus.mac_c), 3);
    bus.op_b = 8'd4; bus.op_c = 8'd5;
    tick();
    check("b2b_en1", 32'(bus.mac_enable), 1);
    check("b2b_b1",  32'(bus.mac_b), 4);
    check("b2b_c1",  32'(bus.mac_c), 5);
    bus.op_b = 8'd1; bus.op_c = 8'd7;
    tick();
    check("b2b_en2", 32'(bus.mac_enable), 1);
    check("b2b_b2",  32'(bus.mac_b), 1);
    check("b2b_c2",  32'(bus.mac_c), 7);
    check("b2b_op_rdy_done", 32'(bus.op_ready), 0);
    bus.op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_drain_en", 32'(bus.mac_enable), 1);
      check("b2b_drain_b",  32'(bus.mac_b), 0);
      check("b2b_drain_c",  32'(bus.mac_c), 0);
    end
    tick();
    check("b2b_capture_en",    32'(bus.mac_enable), 0);
    check("b2b_capture_valid", 32'(bus.res_valid), 0);
    exp_res = marker(cyc);
    tick();
    check("b2b_res_valid", 32'(bus.res_valid), 1);
    check("b2b_res_data",  32'(bus.res_data), 32'(exp_res));
    check("b2b_res_count", 32'(bus.res_count), 3);

    // ---------------- result backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_res_valid", 32'(bus.res_valid), 1);
      check("bp_res_data",  32'(bus.res_data), 32'(exp_res));
      check("bp_cmd_ready", 32'(bus.cmd_ready), 0);
      check("bp_busy",      32'(bus.busy), 1);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bp_after_valid", 32'(bus.res_valid), 0);
    check("bp_after_cmdrdy", 32'(bus.cmd_ready), 1);
    check("bp_after_busy",  32'(bus.busy), 0);

    // ---------------- bubbles, len 2
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd2;
    tick();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_b = 8'd9; bus.op_c = 8'd8;
    tick();
    check("bub_en0", 32'(bus.mac_enable), 1);
    check("bub_b0",  32'(bus.mac_b), 9);
    check("bub_c0",  32'(bus.mac_c), 8);
    bus.op_valid = 1'b0; bus.op_b = 8'd55; bus.op_c = 8'd66;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bub_gap_en", 32'(bus.mac_enable), 0);
      check("bub_gap_b",  32'(bus.mac_b), 0);
      check("bub_gap_c",  32'(bus.mac_c), 0);
    end
    bus.op_valid = 1'b1; bus.op_b = 8'd3; bus.op_c = 8'd4;
    tick();
    bus.op_valid = 1'b0;
    check("bub_en1", 32'(bus.mac_enable), 1);
    check("bub_b1",  32'(bus.mac_b), 3);
    check("bub_c1",  32'(bus.mac_c), 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bub_drain_en", 32'(bus.mac_enable), 1);
      check("bub_drain_b",  32'(bus.mac_b), 0);
    end
    tick();
    check("bub_capture_en", 32'(bus.mac_enable), 0);
    exp_res = marker(cyc);
    tick();
    check("bub_res_valid", 32'(bus.res_valid), 1);
    check("bub_res_data",  32'(bus.res_data), 32'(exp_res));
    check("bub_res_count", 32'(bus.res_count), 2);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bub_done_valid", 32'(bus.res_valid), 0);

    // ---------------- zero length
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd0;
    tick();
    bus.cmd_valid = 1'b0;
    check("zl_capture_en",    32'(bus.mac_enable), 0);
    check("zl_capture_valid", 32'(bus.res_valid), 0);
    check("zl_busy",          32'(bus.busy), 1);
    check("zl_op_ready",      32'(bus.op_ready), 0);
    exp_res = marker(cyc);
    tick();
    check("zl_res_valid", 32'(bus.res_valid), 1);
    check("zl_res_data",  32'(bus.res_data), 32'(exp_res));
    check("zl_res_count", 32'(bus.res_count), 0);
    check("zl_en",        32'(bus.mac_enable), 0);
    // a command offered while a result is pending has no effect
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd7;
    tick();
    bus.cmd_valid = 1'b0;
    check("zl_ignore_count", 32'(bus.res_count), 0);
    check("zl_ignore_valid", 32'(bus.res_valid), 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("zl_done_valid", 32'(bus.res_valid), 0);
    check("zl_done_busy",  32'(bus.busy), 0);

    // ---------------- reset mid-stream
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd4;
    bus.op_valid  = 1'b1; bus.op_b = 8'd1; bus.op_c = 8'd1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("mid_en_before", 32'(bus.mac_enable), 1);
    rst_n = 1'b0;
    #1;
    check("mid_cmd_ready_rst", 32'(bus.cmd_ready), 0);
    check("mid_op_ready_rst",  32'(bus.op_ready), 0);
    tick();
    check("mid_en",        32'(bus.mac_enable), 0);
    check("mid_busy",      32'(bus.busy), 0);
    check("mid_res_valid", 32'(bus.res_valid), 0);
    rst_n = 1'b1;
    bus.op_valid = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_b = 8'd6; bus.op_c = 8'd7;
    tick();
    bus.op_valid = 1'b0;
    check("mid_job_en", 32'(bus.mac_enable), 1);
    check("mid_job_b",  32'(bus.mac_b), 6);
    check("mid_job_c",  32'(bus.mac_c), 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_job_drain", 32'(bus.mac_enable), 1);
    end
    tick();
    check("mid_job_capture_en", 32'(bus.mac_enable), 0);
    exp_res = marker(cyc);
    tick();
    check("mid_job_res_valid", 32'(bus.res_valid), 1);
    check("mid_job_res_data",  32'(bus.res_data), 32'(exp_res));
    check("mid_job_res_count", 32'(bus.res_count), 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // ---------------- maximum length, 255 pairs of 255/255
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd255;
    bus.op_valid  = 1'b1; bus.op_b = 8'd255; bus.op_c = 8'd255;
    tick();
    bus.cmd_valid = 1'b0;
    dcnt = 0; zcnt = 0; ocnt = 0; got = 0; bad_ready = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      tick();
      if (bus.mac_enable) begin
        if (bus.mac_b == 8'd255 && bus.mac_c == 8'd255) dcnt = dcnt + 1;
        else if (bus.mac_b == 8'd0 && bus.mac_c == 8'd0) zcnt = zcnt + 1;
        else ocnt = ocnt + 1;
      end
      if (dcnt == 255 && bus.op_ready) bad_ready = 1;
      if (bus.res_valid) got = 1;
    end
    check("max_result_seen",  32'(got), 1);
    check("max_data_enables", 32'(dcnt), 255);
    check("max_drain_enables", 32'(zcnt), 3);
    check("max_other_enables", 32'(ocnt), 0);
    check("max_op_ready_low", 32'(bad_ready), 0);
    check("max_res_count",    32'(bus.res_count), 255);
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("max_done_valid", 32'(bus.res_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
